draw_rect_ctl: RTL and testbench



---
 rtl/draw_rect_pkg.sv | 24 ++
 rtl/edge_rise.sv | 27 ++
 rtl/draw_rect_ctl.sv | 163 ++++++++++++++++
 tb/tb_draw_rect_ctl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/draw_rect_pkg.sv
// Shared types and screen geometry for the rectangle sprite path.
package draw_rect_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FALL,
    RISE,
    REST
  } rect_state_t;

  // Active screen area.
  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;

  // Default sprite size, shared with draw_rect.
  localparam int DEF_RECT_WIDTH  = 48;
  localparam int DEF_RECT_HEIGHT = 64;

  // Datapath widths: screen coordinates, one-bit-wider sums, velocity magnitude.
  localparam int POS_W = 12;
  localparam int SUM_W = 13;
  localparam int VEL_W = 7;

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector with synchronous active-low reset.
// After reset the input must be seen low once before an edge is reported,
// so a level already high during reset never yields a spurious pulse.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic din_q;
  logic armed;

  // Delay the input by one clock and arm once it has been observed low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      din_q <= din;
      armed <= armed | ~din;
    end
  end

  assign pulse = din & ~din_q & armed;

endmodule

// File: rtl/draw_rect_ctl.sv
// Rectangle sprite position sequencer: follows the mouse while idle, and on a
// left click drops under gravity with damped floor bounces until it rests.
// Position advances once per frame on the rising edge of vblnk.
module draw_rect_ctl
  import draw_rect_pkg::*;
#(
  parameter int RECT_WIDTH  = DEF_RECT_WIDTH,
  parameter int RECT_HEIGHT = DEF_RECT_HEIGHT,
  parameter int X_MAX       = H_ACTIVE - RECT_WIDTH,
  parameter int FLOOR_Y     = V_ACTIVE - RECT_HEIGHT,
  parameter int G           = 1,
  parameter int V_MAX       = 63,
  parameter int DAMP_SHIFT  = 2,
  parameter int V_MIN       = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vblnk,
  input  logic [POS_W-1:0]  mouse_xpos,
  input  logic [POS_W-1:0]  mouse_ypos,
  input  logic              mouse_left,
  output logic [POS_W-1:0]  r_xpos,
  output logic [POS_W-1:0]  r_ypos,
  output logic              busy,
  output logic              rest_pulse
);

  // Upper-bound saturation of a 13-bit sum into a screen coordinate.
  function automatic logic [POS_W-1:0] sat_hi(input logic [SUM_W-1:0] v,
                                              input logic [SUM_W-1:0] lim);
    return (v > lim) ? lim[POS_W-1:0] : v[POS_W-1:0];
  endfunction

  // Velocity saturation at V_MAX.
  function automatic logic [VEL_W-1:0] sat_vel(input logic [SUM_W-1:0] v);
    return (v > SUM_W'(V_MAX)) ? VEL_W'(V_MAX) : v[VEL_W-1:0];
  endfunction

  // Ceiling clamp: negative heights pin to row 0.
  function automatic logic [POS_W-1:0] sat_zero(input logic signed [SUM_W:0] v);
    return (v < 0) ? '0 : v[POS_W-1:0];
  endfunction

  rect_state_t              state;
  rect_state_t              state_next;
  logic [VEL_W-1:0]         vel;
  logic [VEL_W-1:0]         vel_next;
  logic [POS_W-1:0]         x_next;
  logic [POS_W-1:0]         y_next;
  logic                     tick;
  logic                     click;
  logic [VEL_W-1:0]         vn;
  logic [VEL_W-1:0]         vd;
  logic [SUM_W-1:0]         yn;
  logic signed [SUM_W:0]    yr;

  edge_rise u_vblnk_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (vblnk),
    .pulse (tick)
  );

  edge_rise u_left_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (mouse_left),
    .pulse (click)
  );

  // Next-state and next-position logic for one frame step.
  always_comb begin
    state_next = state;
    x_next     = r_xpos;
    y_next     = r_ypos;
    vel_next   = vel;

    // Falling step: accelerate, then advance downward.
    vn = sat_vel(SUM_W'(vel) + SUM_W'(G));
    yn = SUM_W'(r_ypos) + SUM_W'(vn);
    // Bounce loss applied to the impact speed.
    vd = vn - (vn >> DAMP_SHIFT);
    // Rising step: move up by the current speed, may go below row 0.
    yr = $signed({2'b00, r_ypos}) - $signed({7'b0000000, vel});

    unique case (state)
      IDLE: begin
        if (tick) begin
          x_next = sat_hi(SUM_W'(mouse_xpos), SUM_W'(X_MAX));
          y_next = sat_hi(SUM_W'(mouse_ypos), SUM_W'(FLOOR_Y));
        end
        if (click) begin
          state_next = FALL;
          vel_next   = '0;
        end
      end
      FALL: begin
        if (tick) begin
          if (yn < SUM_W'(FLOOR_Y)) begin
            y_next   = yn[POS_W-1:0];
            vel_next = vn;
          end else begin
            y_next = POS_W'(FLOOR_Y);
            if (vd < VEL_W'(V_MIN)) begin
              vel_next   = '0;
              state_next = REST;
            end else begin
              vel_next   = vd;
              state_next = RISE;
            end
          end
        end
      end
      RISE: begin
        if (tick) begin
          if (vel <= VEL_W'(G)) begin
            // Apex: speed spent, turn around without moving this frame.
            vel_next   = '0;
            state_next = FALL;
          end else begin
            y_next   = sat_zero(yr);
            vel_next = vel - VEL_W'(G);
          end
        end
      end
      REST: begin
        if (click) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Position, velocity and registered status decodes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xpos     <= '0;
      r_ypos     <= '0;
      vel        <= '0;
      busy       <= 1'b0;
      rest_pulse <= 1'b0;
    end else begin
      r_xpos     <= x_next;
      r_ypos     <= y_next;
      vel        <= vel_next;
      busy       <= (state_next == FALL) || (state_next == RISE);
      rest_pulse <= (state_next == REST) && (state != REST);
    end
  end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Scoreboard bench for draw_rect_ctl: stimulus queues the expected outputs
// with the cycle they are due; a monitor compares them on the falling edge.
module tb_draw_rect_ctl;

  logic        clk;
  logic        rst_n;
  logic        vblnk;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic [11:0] r_xpos;
  logic [11:0] r_ypos;
  logic        busy;
  logic        rest_pulse;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          sb_stamp[$];
  string       sb_name[$];
  logic [25:0] sb_val[$];
  logic [25:0] act;
  logic [25:0] want;

  draw_rect_ctl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vblnk      (vblnk),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .mouse_left (mouse_left),
    .r_xpos     (r_xpos),
    .r_ypos     (r_ypos),
    .busy       (busy),
    .rest_pulse (rest_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the entry due this cycle.
  always @(negedge clk) begin
    if (sb_stamp.size() > 0 && sb_stamp[0] <= cyc) begin
      act  = {r_xpos, r_ypos, busy, rest_pulse};
      want = sb_val[0];
      checks++;
      if (sb_stamp[0] < cyc) begin
        errors++;
        $display("FAIL %s: slot missed, due cycle %0d now %0d", sb_name[0], sb_stamp[0], cyc);
      end else if (act !== want) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d busy=%0d rest=%0d, want x=%0d y=%0d busy=%0d rest=%0d",
                 sb_name[0], act[25:14], act[13:2], act[1], act[0],
                 want[25:14], want[13:2], want[1], want[0]);
      end
      void'(sb_stamp.pop_front());
      void'(sb_name.pop_front());
      void'(sb_val.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string nm, input int x, input int y,
                          input logic b, input logic r, input int dly);
    sb_stamp.push_back(cyc + dly);
    sb_name.push_back(nm);
    sb_val.push_back({12'(x), 12'(y), b, r});
  endtask

  task automatic tick();
    vblnk = 1'b1;
    step(1);
    vblnk = 1'b0;
    step(1);
  endtask

  task automatic click();
    mouse_left = 1'b1;
    step(1);
    mouse_left = 1'b0;
    step(1);
  endtask

  task automatic tick_exp(input string nm, input int x, input int y,
                          input logic b, input logic r);
    push_exp(nm, x, y, b, r, 1);
    tick();
  endtask

  int y;

  initial begin
    rst_n      = 1'b0;
    vblnk      = 1'b0;
    mouse_xpos = '0;
    mouse_ypos = '0;
    mouse_left = 1'b0;

    // Reset and mouse follow.
    step(4);
    push_exp("reset", 0, 0, 1'b0, 1'b0, 0);
    rst_n = 1'b1;
    step(1);
    mouse_xpos = 12'd100; mouse_ypos = 12'd200;
    tick_exp("follow", 100, 200, 1'b0, 1'b0);
    mouse_xpos = 12'd1000; mouse_ypos = 12'd760;
    tick_exp("clamp", 976, 704, 1'b0, 1'b0);
    step(5);
    push_exp("frozen", 976, 704, 1'b0, 1'b0, 0);

    // Free fall from (100,0); clicks mid-fall are ignored, x is frozen.
    mouse_xpos = 12'd100; mouse_ypos = 12'd0;
    tick_exp("load", 100, 0, 1'b0, 1'b0);
    push_exp("click_fall", 100, 0, 1'b1, 1'b0, 1);
    click();
    mouse_xpos = 12'd500; mouse_ypos = 12'd300;
    for (int k = 1; k <= 37; k++) begin
      tick_exp($sformatf("fall_t%0d", k), 100, k * (k + 1) / 2, 1'b1, 1'b0);
      if (k == 10) begin
        push_exp("fall_click", 100, 55, 1'b1, 1'b0, 1);
        click();
      end
    end
    // Floor hit at speed 38 rebounds at 29.
    tick_exp("floor1", 100, 704, 1'b1, 1'b0);
    tick_exp("rise1", 100, 675, 1'b1, 1'b0);
    push_exp("rise_click", 100, 675, 1'b1, 1'b0, 1);
    click();
    y = 675;
    for (int v = 28; v >= 2; v--) begin
      y = y - v;
      tick_exp($sformatf("rise_v%0d", v), 100, y, 1'b1, 1'b0);
    end
    tick_exp("apex1", 100, 270, 1'b1, 1'b0);
    for (int k = 1; k <= 28; k++) begin
      tick_exp($sformatf("fall2_t%0d", k), 100, 270 + k * (k + 1) / 2, 1'b1, 1'b0);
    end
    // Second impact at 29 rebounds at 22: a lower bounce.
    tick_exp("floor2", 100, 704, 1'b1, 1'b0);
    tick_exp("rise2", 100, 682, 1'b1, 1'b0);

    // Reset mid-rise with vblnk held high across it.
    vblnk = 1'b1;
    rst_n = 1'b0;
    push_exp("rst_mid", 0, 0, 1'b0, 1'b0, 1);
    step(1);
    rst_n = 1'b1;
    mouse_xpos = 12'd300; mouse_ypos = 12'd50;
    step(3);
    push_exp("no_spurious", 0, 0, 1'b0, 1'b0, 0);
    vblnk = 1'b0;
    step(1);
    tick_exp("post_rst", 300, 50, 1'b0, 1'b0);

    // Drop from one pixel above the floor: impact speed 1 damps below V_MIN.
    mouse_xpos = 12'd100; mouse_ypos = 12'd703;
    tick_exp("to703", 100, 703, 1'b0, 1'b0);
    push_exp("drop", 100, 703, 1'b1, 1'b0, 1);
    click();
    push_exp("rest", 100, 704, 1'b0, 1'b1, 1);
    push_exp("rest_pulse_end", 100, 704, 1'b0, 1'b0, 2);
    tick();
    mouse_xpos = 12'd640; mouse_ypos = 12'd480;
    tick_exp("rest_hold", 100, 704, 1'b0, 1'b0);
    push_exp("rest_click", 100, 704, 1'b0, 1'b0, 1);
    click();
    tick_exp("resume", 640, 480, 1'b0, 1'b0);

    // Tick and click on the same edge in IDLE.
    mouse_xpos = 12'd300; mouse_ypos = 12'd50;
    vblnk = 1'b1;
    mouse_left = 1'b1;
    push_exp("tick_click", 300, 50, 1'b1, 1'b0, 1);
    step(1);
    vblnk = 1'b0;
    mouse_left = 1'b0;
    step(1);
    tick_exp("fall1", 300, 51, 1'b1, 1'b0);

    for (int i = 0; i < 20 && sb_stamp.size() > 0; i++) step(1);
    if (sb_stamp.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb_stamp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
